// File: rtl/sprite_render_pkg.sv
// Shared VGA constants for the sync, sprite RAM and sprite render stages.
// Holds default screen/sprite geometry, the transparent key colour and the origin clamp.
package sprite_render_pkg;

    localparam int H_MAX_DEF    = 640;
    localparam int V_MAX_DEF    = 480;
    localparam int SPRITE_W_DEF = 64;
    localparam int SPRITE_H_DEF = 64;
    localparam logic [11:0] KEY_COLOR_DEF = 12'hF0F;

    // Keeps a requested sprite edge far enough from the screen edge that the sprite stays whole.
    function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/sprite_render.sv
// Overlays a SPRITE_W x SPRITE_H sprite at a per-frame latched origin on the VGA scan.
// Two-cycle pipeline: address out on the pixel cycle, RAM read, then registered colour.
module sprite_render
    import sprite_render_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12,
    parameter int SPRITE_W   = SPRITE_W_DEF,
    parameter int SPRITE_H   = SPRITE_H_DEF,
    parameter int H_MAX      = H_MAX_DEF,
    parameter int V_MAX      = V_MAX_DEF,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR = DATA_WIDTH'(KEY_COLOR_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            x,
    input  logic [9:0]            y,
    input  logic                  video_on,
    input  logic                  frame_tick,
    input  logic [9:0]            pos_x,
    input  logic [9:0]            pos_y,
    input  logic                  flip_h,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] sprite_rgb,
    output logic                  sprite_on
);

    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    localparam logic [9:0]  OX_MAX = 10'(H_MAX - SPRITE_W);
    localparam logic [9:0]  OY_MAX = 10'(V_MAX - SPRITE_H);
    localparam logic [10:0] SW11   = 11'(SPRITE_W);
    localparam logic [10:0] SH11   = 11'(SPRITE_H);

    logic [9:0]            ox_reg;
    logic [9:0]            oy_reg;
    logic                  flip_reg;
    logic                  hit_d1_reg;
    logic                  sprite_on_reg;
    logic [DATA_WIDTH-1:0] sprite_rgb_reg;

    logic [10:0]   x_end;
    logic [10:0]   y_end;
    logic          hit;
    logic [CW-1:0] col_raw;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // 11-bit bounds so ox+SPRITE_W near the right edge cannot wrap back into range.
    assign x_end = {1'b0, ox_reg} + SW11;
    assign y_end = {1'b0, oy_reg} + SH11;

    assign hit = video_on
              && ({1'b0, x} >= {1'b0, ox_reg}) && ({1'b0, x} < x_end)
              && ({1'b0, y} >= {1'b0, oy_reg}) && ({1'b0, y} < y_end);

    assign col_raw = x[CW-1:0] - ox_reg[CW-1:0];
    assign row     = y[RW-1:0] - oy_reg[RW-1:0];
    // SPRITE_W is a power of two, so SPRITE_W-1-col is just the bitwise inverse.
    assign col     = flip_reg ? ~col_raw : col_raw;

    assign ram_addr = hit ? ADDR_WIDTH'({row, col}) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ox_reg         <= '0;
            oy_reg         <= '0;
            flip_reg       <= 1'b0;
            hit_d1_reg     <= 1'b0;
            sprite_on_reg  <= 1'b0;
            sprite_rgb_reg <= '0;
        end else begin
            if (frame_tick) begin
                ox_reg   <= clamp10(pos_x, OX_MAX);
                oy_reg   <= clamp10(pos_y, OY_MAX);
                flip_reg <= flip_h;
            end
            hit_d1_reg     <= hit;
            sprite_on_reg  <= hit_d1_reg && (ram_dout != KEY_COLOR);
            sprite_rgb_reg <= hit_d1_reg ? ram_dout : '0;
        end
    end

    assign sprite_on  = sprite_on_reg;
    assign sprite_rgb = sprite_rgb_reg;

endmodule

// File: doc/sprite_render.md
SPRITE_RENDER -- requirements
Module: sprite_render

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 12, pixel colour width (4:4:4 RGB).
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 12, sprite RAM address width (64x64 image).
REQ-003 The module SHALL have parameters SPRITE_W and SPRITE_H, default 64 each, sprite size in pixels; both SHALL be powers of two with log2(SPRITE_W)+log2(SPRITE_H) = ADDR_WIDTH.
REQ-004 The module SHALL have parameters H_MAX and V_MAX, default 640 and 480, visible screen size.
REQ-005 The module SHALL have parameter KEY_COLOR, default 12'hF0F, transparent colour.
REQ-006 Ports, in this order:
  clk  in  1  system clock; single clock domain.
  reset  in  1  synchronous, active-high reset.
  x  in  10  current pixel column from the VGA sync stage.
  y  in  10  current pixel row.
  video_on  in  1  high when (x,y) is inside the visible area.
  frame_tick  in  1  one-cycle pulse once per frame, asserted during vertical blanking.
  pos_x  in  10  requested sprite left edge (mouse position).
  pos_y  in  10  requested sprite top edge.
  flip_h  in  1  horizontal mirror request.
  ram_addr  out  ADDR_WIDTH  read address to the sprite RAM (1-cycle registered read).
  ram_dout  in  DATA_WIDTH  sprite RAM read data.
  sprite_rgb  out  DATA_WIDTH  registered sprite pixel colour.
  sprite_on  out  1  registered: sprite pixel is opaque at this position.

Function
REQ-007 Origin registers ox, oy and flip register SHALL load only on frame_tick, so position and mirroring never change mid-frame.
REQ-008 On load, ox SHALL be min(pos_x, H_MAX-SPRITE_W) and oy SHALL be min(pos_y, V_MAX-SPRITE_H); e.g. pos_x=630 -> ox=576.
REQ-009 Hit (combinational) SHALL be video_on AND ox<=x<ox+SPRITE_W AND oy<=y<oy+SPRITE_H, computed with 11-bit arithmetic so the sum cannot wrap.
REQ-010 col = x-ox, row = y-oy (truncated to log2 width/height); if flip, col = SPRITE_W-1-col.
REQ-011 ram_addr SHALL be combinational {row, col} when hit, else all zeros.
REQ-012 Pipeline: hit registered into hit_d1 at the edge on which the RAM samples ram_addr; in the following cycle ram_dout is valid for that pixel.
REQ-013 sprite_on SHALL register hit_d1 AND (ram_dout != KEY_COLOR); sprite_rgb SHALL register ram_dout when hit_d1 is high, else zero.
REQ-014 Total latency from (x,y) presented to sprite_on/sprite_rgb valid SHALL be exactly 2 clock cycles; throughput one pixel per cycle.
REQ-015 frame_tick coincident with a hit pixel: that pixel SHALL use the old origin; the new origin applies from the next cycle.
REQ-016 x,y outside the visible area or video_on low SHALL never produce sprite_on, regardless of origin.
REQ-017 Pixels at x=ox+SPRITE_W or y=oy+SPRITE_H SHALL be misses (exclusive upper bound).

Reset
REQ-018 While reset is high at a clock edge: ox, oy, flip, hit_d1, sprite_on and sprite_rgb SHALL become 0; frame_tick is ignored.
REQ-019 Reset asserted mid-frame SHALL flush the pipeline: the two cycles after reset deassertion SHALL output sprite_on=0 unless new hits enter.

Structure
REQ-020 Default screen size, sprite size and KEY_COLOR SHALL live in the shared VGA package as constants, reused by the sync and RAM stages.
REQ-021 The block SHALL be flat apart from optionally instantiating the sprite RAM in a wrapper; no sub-module is required within sprite_render itself.

Verification
REQ-022 Reset, then frame_tick with pos=(100,50), scan x=100,y=50 with RAM word 0 = 12'h123 -> two cycles later sprite_on=1, sprite_rgb=12'h123, ram_addr=0 on the input cycle.
REQ-023 Same origin, pixel x=163,y=113 -> ram_addr=12'hFFF; x=164 -> ram_addr=0, sprite_on=0 two cycles later.
REQ-024 RAM word returns 12'hF0F inside the sprite -> sprite_on=0, sprite_rgb=12'hF0F.
REQ-025 pos=(700,470) on frame_tick -> ox=576, oy=416; flip_h=1 at x=576,y=416 -> ram_addr=12'h03F.
REQ-026 pos changed without frame_tick mid-frame -> hits unchanged; reset asserted during a hit burst -> outputs 0 next cycle, ox=oy=0.
